// File: rtl/uart_atx_pkg.sv
// Shared definitions for the uart_atx AXI4 initiator: FSM state codes,
// AXI burst encodings and AXI response codes.
package uart_atx_pkg;

  // FSM state encoding. Kept as plain constants so older tools that choke on
  // enum-typed ports or state variables can still consume this package.
  localparam int STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 3'd0;  // waiting for a command
  localparam state_t ST_AW   = 3'd1;  // presenting the write address
  localparam state_t ST_W    = 3'd2;  // streaming write beats
  localparam state_t ST_B    = 3'd3;  // waiting for the write response
  localparam state_t ST_AR   = 3'd4;  // presenting the read address
  localparam state_t ST_R    = 3'd5;  // streaming read beats
  localparam state_t ST_RSP  = 3'd6;  // reporting completion upstream

  // AXI burst type. Only FIXED is issued by this initiator.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage : uart_atx_pkg

// File: rtl/uart_atx_master.sv
// AXI4 initiator with a single outstanding transaction. A command on the
// cmd_* port becomes one AXI burst (FIXED type); write beats are taken from
// the wd_* stream, read beats are delivered on the rd_* stream, and the
// final status is reported on the rsp_* port.
module uart_atx_master
  import uart_atx_pkg::*;
#(
  parameter int ATX_DATA_W = 8,
  parameter int ATX_ADDR_W = 32,
  parameter int ATX_ID_W   = 5,
  parameter int ATX_LEN_W  = 8,
  parameter int ATX_RESP_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  // Command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ATX_ID_W-1:0]   cmd_id,
  input  logic [ATX_ADDR_W-1:0] cmd_addr,
  input  logic [ATX_LEN_W-1:0]  cmd_len,

  // Write-beat stream
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [ATX_DATA_W-1:0] wd_data,

  // Read-beat stream
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ATX_DATA_W-1:0] rd_data,
  output logic                  rd_last,

  // Completion port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wr,
  output logic [ATX_ID_W-1:0]   rsp_id,
  output logic [ATX_RESP_W-1:0] rsp_resp,

  // AXI4 write address channel
  output logic [ATX_ID_W-1:0]   m_awid,
  output logic [ATX_ADDR_W-1:0] m_awaddr,
  output logic [1:0]            m_awburst,
  output logic [ATX_LEN_W-1:0]  m_awlen,
  output logic                  m_awvalid,
  input  logic                  m_awready,

  // AXI4 write data channel
  output logic [ATX_DATA_W-1:0] m_wdata,
  output logic                  m_wlast,
  output logic                  m_wvalid,
  input  logic                  m_wready,

  // AXI4 write response channel
  input  logic [ATX_ID_W-1:0]   m_bid,
  input  logic [ATX_RESP_W-1:0] m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,

  // AXI4 read address channel
  output logic [ATX_ID_W-1:0]   m_arid,
  output logic [ATX_ADDR_W-1:0] m_araddr,
  output logic [1:0]            m_arburst,
  output logic [ATX_LEN_W-1:0]  m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,

  // AXI4 read data channel
  input  logic [ATX_ID_W-1:0]   m_rid,
  input  logic [ATX_DATA_W-1:0] m_rdata,
  input  logic [ATX_RESP_W-1:0] m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  localparam logic [ATX_RESP_W-1:0] RSP_OKAY   = ATX_RESP_W'(RESP_OKAY);
  localparam logic [ATX_RESP_W-1:0] RSP_SLVERR = ATX_RESP_W'(RESP_SLVERR);

  // Registered state and the fields latched from the accepted command.
  state_t                  state_q, state_d;
  logic                    wr_q,    wr_d;
  logic [ATX_ID_W-1:0]     id_q,    id_d;
  logic [ATX_ADDR_W-1:0]   addr_q,  addr_d;
  logic [ATX_LEN_W-1:0]    len_q,   len_d;
  logic [ATX_LEN_W-1:0]    cnt_q,   cnt_d;
  logic [ATX_RESP_W-1:0]   resp_q,  resp_d;

  // Beat counter has reached the final beat of the burst. Because the count
  // stops at len and is cleared on leaving the data phase, len = 255 never
  // wraps the counter.
  logic beat_is_last;
  assign beat_is_last = (cnt_q == len_q);

  // Handshakes seen by the FSM, qualified by the state that owns them.
  logic w_fire, r_fire;
  assign w_fire = (state_q == ST_W) && wd_valid && m_wready;
  assign r_fire = (state_q == ST_R) && m_rvalid && rd_ready;

  // Read IDs are not checked; only the write response ID is compared.
  logic unused_rid;
  assign unused_rid = ^m_rid;

  // Sequential state update with synchronous reset of every register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state logic: command capture, beat counting and response tracking.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    wr_d    = wr_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_wr;
          id_d    = cmd_id;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = '0;
          resp_d  = RSP_OKAY;
          state_d = cmd_wr ? ST_AW : ST_AR;
        end
      end

      ST_AW: begin
        if (m_awready) state_d = ST_W;
      end

      ST_W: begin
        if (w_fire) begin
          if (beat_is_last) begin
            cnt_d   = '0;
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q + ATX_LEN_W'(1);
          end
        end
      end

      ST_B: begin
        if (m_bvalid) begin
          // A response tagged with someone else's ID is reported as an error.
          resp_d  = (m_bid != id_q) ? RSP_SLVERR : m_bresp;
          state_d = ST_RSP;
        end
      end

      ST_AR: begin
        if (m_arready) state_d = ST_R;
      end

      ST_R: begin
        if (r_fire) begin
          // Worst response across the burst wins.
          resp_d = (m_rresp > resp_q) ? m_rresp : resp_q;
          // rlast must coincide with beat len: early or missing is an error.
          if (m_rlast != beat_is_last) resp_d = RSP_SLVERR;
          if (m_rlast || beat_is_last) begin
            cnt_d   = '0;
            state_d = ST_RSP;
          end else begin
            cnt_d = cnt_q + ATX_LEN_W'(1);
          end
        end
      end

      ST_RSP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state; data channels are
  // straight pass-throughs while their owning state is active.
  always_comb begin
    cmd_ready = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    wd_ready  = 1'b0;
    m_wdata   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    rd_valid  = 1'b0;
    m_rready  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      // Held low while rst is asserted so nothing is accepted mid-reset.
      ST_IDLE: cmd_ready = ~rst;
      ST_AW:   m_awvalid = 1'b1;
      ST_W: begin
        m_wvalid = wd_valid;
        wd_ready = m_wready;
        m_wdata  = wd_data;
        m_wlast  = beat_is_last;
      end
      ST_B:    m_bready  = 1'b1;
      ST_AR:   m_arvalid = 1'b1;
      ST_R: begin
        rd_valid = m_rvalid;
        m_rready = rd_ready;
        rd_data  = m_rdata;
        rd_last  = m_rlast;
      end
      ST_RSP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Address payloads come straight from the latched command, so they are
  // stable for as long as the matching valid is held.
  assign m_awid    = id_q;
  assign m_awaddr  = addr_q;
  assign m_awburst = BURST_FIXED;
  assign m_awlen   = len_q;

  assign m_arid    = id_q;
  assign m_araddr  = addr_q;
  assign m_arburst = BURST_FIXED;
  assign m_arlen   = len_q;

  assign rsp_wr    = wr_q;
  assign rsp_id    = id_q;
  assign rsp_resp  = resp_q;

endmodule : uart_atx_master

// File: tb/tb_uart_atx_master.sv
// Directed testbench for uart_atx_master. The bench plays both the command
// source and the AXI slave; inputs change just after the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_uart_atx_master;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int IW = 5;
  localparam int LW = 8;
  localparam int RW = 2;
  localparam int WAIT_BUDGET = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_wr;
  logic [IW-1:0] cmd_id;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          rsp_valid, rsp_ready, rsp_wr;
  logic [IW-1:0] rsp_id;
  logic [RW-1:0] rsp_resp;
  logic [IW-1:0] m_awid, m_arid, m_bid, m_rid;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [1:0]    m_awburst, m_arburst;
  logic [LW-1:0] m_awlen, m_arlen;
  logic          m_awvalid, m_awready, m_arvalid, m_arready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_wlast, m_wvalid, m_wready;
  logic [RW-1:0] m_bresp, m_rresp;
  logic          m_bvalid, m_bready;
  logic          m_rlast, m_rvalid, m_rready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_atx_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_id    (cmd_id),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wd_valid  (wd_valid),
    .wd_ready  (wd_ready),
    .wd_data   (wd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_wr    (rsp_wr),
    .rsp_id    (rsp_id),
    .rsp_resp  (rsp_resp),
    .m_awid    (m_awid),
    .m_awaddr  (m_awaddr),
    .m_awburst (m_awburst),
    .m_awlen   (m_awlen),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wlast   (m_wlast),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bid     (m_bid),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_arid    (m_arid),
    .m_araddr  (m_araddr),
    .m_arburst (m_arburst),
    .m_arlen   (m_arlen),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rid     (m_rid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0:       return m_awvalid;
      1:       return m_arvalid;
      default: return rsp_valid;
    endcase
  endfunction

  // Called just after a falling edge; returns 1 ns later with the signal high
  // or with a timeout recorded as a failure.
  task automatic wait_hi(input int which, input string tag);
    int n = 0;
    #1;
    while (!sig_sel(which) && n < WAIT_BUDGET) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!sig_sel(which)) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic send_cmd(input logic wr, input logic [IW-1:0] id,
                          input logic [AW-1:0] addr, input logic [LW-1:0] len);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_aw(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                       input logic [IW-1:0] id, input int stall);
    wait_hi(0, "awvalid");
    check("awaddr", m_awaddr, addr);
    check("awlen", m_awlen, len);
    check("awid", m_awid, id);
    check("awburst", m_awburst, 2'b00);
    check("no_w_before_aw", m_wvalid | wd_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      check("awvalid_held", m_awvalid, 1);
      check("awaddr_stable", m_awaddr, addr);
    end
    m_awready = 1'b1;
    @(negedge clk);
    m_awready = 1'b0;
  endtask

  task automatic w_beat(input logic [DW-1:0] data, input logic exp_last, input int stall);
    wd_valid = 1'b1; wd_data = data; m_wready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      check("wvalid_stall", m_wvalid, 1);
      check("wdata_stall", m_wdata, data);
      check("wlast_stall", m_wlast, exp_last);
      @(negedge clk);
    end
    m_wready = 1'b1;
    #1;
    check("wvalid", m_wvalid, 1);
    check("wd_ready", wd_ready, 1);
    check("wdata", m_wdata, data);
    check("wlast", m_wlast, exp_last);
    @(negedge clk);
    wd_valid = 1'b0; m_wready = 1'b0;
  endtask

  task automatic do_b(input logic [IW-1:0] bid, input logic [RW-1:0] bresp);
    m_bvalid = 1'b1; m_bid = bid; m_bresp = bresp;
    #1;
    check("bready", m_bready, 1);
    check("rsp_not_early_b", rsp_valid, 0);
    @(negedge clk);
    m_bvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [AW-1:0] addr, input logic [LW-1:0] len, input logic [IW-1:0] id);
    wait_hi(1, "arvalid");
    check("araddr", m_araddr, addr);
    check("arlen", m_arlen, len);
    check("arid", m_arid, id);
    check("arburst", m_arburst, 2'b00);
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
  endtask

  task automatic r_beat(input logic [DW-1:0] data, input logic last, input logic [RW-1:0] resp);
    m_rvalid = 1'b1; m_rdata = data; m_rlast = last; m_rresp = resp; rd_ready = 1'b1;
    #1;
    check("rd_valid", rd_valid, 1);
    check("m_rready", m_rready, 1);
    check("rd_data", rd_data, data);
    check("rd_last", rd_last, last);
    check("rsp_not_early_r", rsp_valid, 0);
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic do_rsp(input logic wr, input logic [IW-1:0] id, input logic [RW-1:0] resp);
    wait_hi(2, "rsp_valid");
    check("rsp_wr", rsp_wr, wr);
    check("rsp_id", rsp_id, id);
    check("rsp_resp", rsp_resp, resp);
    check("cmd_ready_busy", cmd_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("rsp_dropped", rsp_valid, 0);
    check("back_to_idle", cmd_ready, 1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_wr = 0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 0; wd_data = '0; rd_ready = 0; rsp_ready = 0;
    m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0;
    m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    #1 check("cmd_ready_after_rst", cmd_ready, 1);
    @(negedge clk);

    // Single-beat write, len 0
    send_cmd(1'b1, 5'h00, 32'h2000_0000, 8'd0);
    do_aw(32'h2000_0000, 8'd0, 5'h00, 0);
    w_beat(8'h33, 1'b1, 0);
    do_b(5'h00, 2'b00);
    do_rsp(1'b1, 5'h00, 2'b00);

    // Two-beat write with AW stall and a 3-cycle W stall on the last beat
    send_cmd(1'b1, 5'h01, 32'h2000_0010, 8'd1);
    do_aw(32'h2000_0010, 8'd1, 5'h01, 2);
    w_beat(8'h11, 1'b0, 0);
    w_beat(8'hEE, 1'b1, 3);
    do_b(5'h01, 2'b00);
    do_rsp(1'b1, 5'h01, 2'b00);

    // Two-beat read, rlast on beat 1
    send_cmd(1'b0, 5'h02, 32'h2000_0020, 8'd1);
    do_ar(32'h2000_0020, 8'd1, 5'h02);
    r_beat(8'h11, 1'b0, 2'b00);
    r_beat(8'hEE, 1'b1, 2'b00);
    do_rsp(1'b0, 5'h02, 2'b00);

    // len 3 read with early rlast on beat 1 -> SLVERR, burst closes at beat 1
    send_cmd(1'b0, 5'h03, 32'h2000_0024, 8'd3);
    do_ar(32'h2000_0024, 8'd3, 5'h03);
    r_beat(8'hA0, 1'b0, 2'b00);
    r_beat(8'hA1, 1'b1, 2'b00);
    do_rsp(1'b0, 5'h03, 2'b10);

    // len 1 read with rlast missing on beat 1 -> SLVERR
    send_cmd(1'b0, 5'h05, 32'h2000_0028, 8'd1);
    do_ar(32'h2000_0028, 8'd1, 5'h05);
    r_beat(8'h01, 1'b0, 2'b00);
    r_beat(8'h02, 1'b0, 2'b00);
    do_rsp(1'b0, 5'h05, 2'b10);

    // len 2 read: response is the max over beats (00, 01, 00 -> 01)
    send_cmd(1'b0, 5'h06, 32'h2000_002C, 8'd2);
    do_ar(32'h2000_002C, 8'd2, 5'h06);
    r_beat(8'h10, 1'b0, 2'b00);
    r_beat(8'h20, 1'b0, 2'b01);
    r_beat(8'h30, 1'b1, 2'b00);
    do_rsp(1'b0, 5'h06, 2'b01);

    // len 255 read: 256 beats with no counter wrap
    send_cmd(1'b0, 5'h04, 32'h2000_0100, 8'd255);
    do_ar(32'h2000_0100, 8'd255, 5'h04);
    for (int i = 0; i < 256; i++) r_beat(8'(i), (i == 255), 2'b00);
    do_rsp(1'b0, 5'h04, 2'b00);

    // Reset during W beat 1 of a len 3 write
    send_cmd(1'b1, 5'h07, 32'h2000_0030, 8'd3);
    do_aw(32'h2000_0030, 8'd3, 5'h07, 0);
    w_beat(8'hB0, 1'b0, 0);
    wd_valid = 1'b1; wd_data = 8'hB1; m_wready = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_wvalid", m_wvalid, 0);
    check("midrst_wd_ready", wd_ready, 0);
    check("midrst_awvalid", m_awvalid, 0);
    check("midrst_bready", m_bready, 0);
    check("midrst_arvalid", m_arvalid, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_idle", cmd_ready, 1);
    wd_valid = 1'b0; m_wready = 1'b0;
    @(negedge clk);

    // Next command after reset; B carries a foreign ID -> SLVERR
    send_cmd(1'b1, 5'h00, 32'h2000_0040, 8'd0);
    do_aw(32'h2000_0040, 8'd0, 5'h00, 0);
    w_beat(8'h55, 1'b1, 0);
    do_b(5'h03, 2'b00);
    do_rsp(1'b1, 5'h00, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_uart_atx_master

// File: doc/uart_atx_master.md
UART_ATX_MASTER -- requirements
Module: uart_atx_master

Interface
REQ-001 SHALL have parameter ATX_DATA_W, default 8, AXI4 data width.
REQ-002 SHALL have parameter ATX_ADDR_W, default 32, AXI4 address width.
REQ-003 SHALL have parameter ATX_ID_W, default 5, AXI4 ID width.
REQ-004 SHALL have parameter ATX_LEN_W, default 8, AXI4 burst length width.
REQ-005 SHALL have parameter ATX_RESP_W, default 2, AXI4 response width.
REQ-006 SHALL have the following ports; the design uses one clock, and reset is synchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_id  in  ATX_ID_W  transaction ID.
- cmd_addr  in  ATX_ADDR_W  target address.
- cmd_len  in  ATX_LEN_W  beats minus 1.
- wd_valid/wd_ready/wd_data  in/out/in  1/1/ATX_DATA_W  write-beat stream.
- rd_valid/rd_ready/rd_data/rd_last  out/in/out/out  1/1/ATX_DATA_W/1  read-beat stream.
- rsp_valid/rsp_ready  out/in  1/1  completion handshake.
- rsp_wr/rsp_id/rsp_resp  out  1/ATX_ID_W/ATX_RESP_W  completion info.
- m_awid/m_awaddr/m_awburst/m_awlen/m_awvalid, m_awready  out..., in  AXI4 AW.
- m_wdata/m_wlast/m_wvalid, m_wready  out, in  AXI4 W.
- m_bid/m_bresp/m_bvalid in, m_bready out  AXI4 B.
- m_arid/m_araddr/m_arburst/m_arlen/m_arvalid, m_arready  out..., in  AXI4 AR.
- m_rid/m_rdata/m_rresp/m_rlast/m_rvalid in, m_rready out  AXI4 R.

Function
REQ-007 SHALL be an AXI4 initiator with one outstanding transaction; FSM states IDLE, AW, W, B, AR, R, RSP.
REQ-008 SHALL assert cmd_ready only in IDLE; on cmd handshake, latch id/addr/len/wr and go to AW (wr=1) or AR (wr=0).
REQ-009 SHALL drive m_awburst/m_arburst = 2'b00 (FIXED); m_awlen/m_arlen = latched cmd_len.
REQ-010 SHALL hold each m_*valid high with stable payload until the matching ready; no valid withdrawn before handshake.
REQ-011 SHALL issue W beats only after the AW handshake: m_wvalid = wd_valid, wd_ready = m_wready, m_wdata = wd_data (combinational, state W only).
REQ-012 SHALL count W beats in a ATX_LEN_W-bit counter; m_wlast = 1 when count == latched len; after the last handshake, go to B.
REQ-013 SHALL assert m_bready only in B; on B handshake capture bresp; set resp to 2'b10 if m_bid != latched id; go to RSP.
REQ-014 SHALL pass R beats through in state R: rd_valid = m_rvalid, m_rready = rd_ready, rd_data = m_rdata, rd_last = m_rlast.
REQ-015 SHALL accumulate read resp as the numeric max of all m_rresp beats; force 2'b10 on early m_rlast (count < len) or on a missing m_rlast at beat len; R ends on the first m_rlast or on beat len.
REQ-016 SHALL hold rsp_valid in RSP until rsp_ready, then return to IDLE; minimum one cycle from last B/R handshake to rsp_valid.
REQ-017 len = 0 SHALL produce a single beat with wlast/expected rlast on beat 0; len = 255 SHALL complete 256 beats without counter overflow side effects.

Reset
REQ-018 On rst SHALL enter IDLE, clear counters and latched fields, and drive all valid/ready outputs to 0 (cmd_ready goes 1 the cycle after rst drops), including mid-burst; the bench re-resets the slave alongside.

Structure
REQ-019 SHALL place the FSM state enum, burst encodings (FIXED = 2'b00) and resp codes (OKAY = 2'b00, SLVERR = 2'b10) in shared package uart_atx_pkg.
REQ-020 SHALL be a single module; no sub-module.

Verification
REQ-021 Write id 0, addr 0x2000_0000, len 0, wdata 0x33 -> one AW/W beat, wlast = 1, rsp_resp = 0 with rsp_wr = 1.
REQ-022 Write addr 0x2000_0010, len 1, data 0x11, 0xEE, with m_wready stalled 3 cycles on beat 1 -> wlast only on 0xEE, payload stable during stall.
REQ-023 Read addr 0x2000_0020, len 1, slave returns 0x11, 0xEE, rlast on beat 1 -> rd stream identical, rsp_resp = 0.
REQ-024 Read len 3, slave asserts rlast on beat 1 -> rsp_resp = 2'b10, return to IDLE.
REQ-025 rst asserted during W beat 1 of a len-3 write -> next cycle all valids 0, state IDLE, next command accepted.
REQ-026 B with m_bid = 5'h03 for cmd_id 5'h00 -> rsp_resp = 2'b10, rsp_id = 0.
